// File: rtl/counter_stream_checker.sv
// counter_stream_checker
// Watches a sampled 14-bit counter stream {hi[5:0], lo[7:0]} and decides
// whether it is advancing by exactly one low step per valid sample. The high
// field may advance by one (mod 64) or stay put when the low field wraps,
// because the sampled counter need not carry on every low wrap.
//
// After LOCK_COUNT consecutive good samples the checker reports lock. A bad
// sample while locked pulses err_pulse, bumps a saturating error counter,
// sets the sticky lock_lost flag and drops back to acquisition. Bad samples
// during acquisition only restart the good-sample run; they are not errors.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no reference yet; the next valid sample becomes the reference
//   ST_ACQUIRE | counting consecutive good samples toward LOCK_COUNT
//   ST_LOCKED  | stream verified; any bad sample is reported as an error
module counter_stream_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [13:0]      in_data,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic             lock_lost,
  output logic [13:0]      last_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Run counter is 4 bits wide, enough for the largest legal LOCK_COUNT (15).
  localparam logic [3:0] LP_LOCK_COUNT = 4'(LOCK_COUNT);

  // Registered state and outputs.
  state_t           r_state;
  logic [3:0]       r_good_run;
  logic             r_locked;
  logic             r_err_pulse;
  logic [ERR_W-1:0] r_err_count;
  logic             r_lock_lost;
  logic [13:0]      r_last_data;

  // Next-state values produced by the combinational process.
  state_t           w_state_nxt;
  logic [3:0]       w_good_run_nxt;
  logic             w_locked_nxt;
  logic             w_err_pulse_nxt;
  logic [ERR_W-1:0] w_err_count_nxt;
  logic             w_lock_lost_nxt;
  logic [13:0]      w_last_data_nxt;

  // Sample classification against the previous accepted word.
  logic [7:0]       w_prev_lo;
  logic [5:0]       w_prev_hi;
  logic [7:0]       w_in_lo;
  logic [5:0]       w_in_hi;
  logic [7:0]       w_lo_inc;
  logic [5:0]       w_hi_inc;
  logic             w_lo_ok;
  logic             w_lo_wrap;
  logic             w_hi_ok;
  logic             w_good;
  logic             w_err_sat;
  logic [3:0]       w_run_inc;

  assign w_prev_lo = r_last_data[7:0];
  assign w_prev_hi = r_last_data[13:8];
  assign w_in_lo   = in_data[7:0];
  assign w_in_hi   = in_data[13:8];

  assign w_lo_inc  = w_prev_lo + 8'd1;
  assign w_hi_inc  = w_prev_hi + 6'd1;
  assign w_lo_ok   = (w_in_lo == w_lo_inc);
  assign w_lo_wrap = (w_prev_lo == 8'hFF);

  // Across a low wrap the high field may hold or advance by one; otherwise it
  // must hold. A repeated word fails the low-field test, so it is always bad.
  assign w_hi_ok   = w_lo_wrap ? ((w_in_hi == w_prev_hi) || (w_in_hi == w_hi_inc))
                               : (w_in_hi == w_prev_hi);
  assign w_good    = w_lo_ok && w_hi_ok;

  assign w_err_sat = &r_err_count;
  assign w_run_inc = r_good_run + 4'd1;

  // Next-state and next-output decode; everything holds unless a valid sample
  // arrives, and err_pulse is only ever a single-cycle strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_good_run_nxt  = r_good_run;
    w_err_pulse_nxt = 1'b0;
    w_err_count_nxt = r_err_count;
    w_lock_lost_nxt = r_lock_lost;
    w_last_data_nxt = r_last_data;

    if (in_valid) begin
      w_last_data_nxt = in_data;

      case (r_state)
        ST_IDLE: begin
          w_good_run_nxt = 4'd0;
          w_state_nxt    = ST_ACQUIRE;
        end

        ST_ACQUIRE: begin
          if (w_good) begin
            w_good_run_nxt = w_run_inc;
            if (w_run_inc >= LP_LOCK_COUNT) begin
              w_state_nxt = ST_LOCKED;
            end
          end else begin
            w_good_run_nxt = 4'd0;
          end
        end

        ST_LOCKED: begin
          if (!w_good) begin
            w_err_pulse_nxt = 1'b1;
            if (!w_err_sat) begin
              w_err_count_nxt = r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            w_lock_lost_nxt = 1'b1;
            w_good_run_nxt  = 4'd0;
            w_state_nxt     = ST_ACQUIRE;
          end
        end

        default: begin
          w_good_run_nxt = 4'd0;
          w_state_nxt    = ST_IDLE;
        end
      endcase
    end

    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  // State and output registers; reset wins over any sample on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_good_run  <= 4'd0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_lock_lost <= 1'b0;
      r_last_data <= 14'h0000;
    end else begin
      r_state     <= w_state_nxt;
      r_good_run  <= w_good_run_nxt;
      r_locked    <= w_locked_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_count <= w_err_count_nxt;
      r_lock_lost <= w_lock_lost_nxt;
      r_last_data <= w_last_data_nxt;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign lock_lost = r_lock_lost;
  assign last_data = r_last_data;

endmodule
